multi_port_reg_file: RTL
========================

MULTI_PORT_REG_FILE -- requirements
Module: multi_port_reg_file

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, address width of every port.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, entry width; multiple of 8; non-multiple fails elaboration.
REQ-003 SHALL have parameter DEPTH, default 32, entry count; 1 <= DEPTH <= 2**ADDR_WIDTH.
REQ-004 SHALL have parameter NUM_READ, default 2, number of independent read ports (>= 1).
REQ-005 SHALL have parameter BYPASS, default 1; 1 = same-cycle write data forwarded to reads.
REQ-006 SHALL have parameter ZERO_REG, default 0; 1 = entry 0 reads zero and ignores writes.
REQ-007 SHALL have parameter READ_REG, default 0; 0 = combinational read, 1 = registered read (1-cycle latency).
REQ-008 SHALL have port clock, input, 1, single clock; all state updates on rising edge.
REQ-009 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-010 SHALL have ports w0_en / w1_en, input, 1 each, write enables for write ports 0 and 1.
REQ-011 SHALL have ports w0_addr / w1_addr, input, ADDR_WIDTH each, write addresses.
REQ-012 SHALL have ports w0_data / w1_data, input, DATA_WIDTH each, write data.
REQ-013 SHALL have ports w0_strb / w1_strb, input, DATA_WIDTH/8 each, byte-lane enables; bit i covers data[8i+7:8i].
REQ-014 SHALL have port r_addr, input, NUM_READ*ADDR_WIDTH, packed read addresses; port k at [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-015 SHALL have port r_data, output, NUM_READ*DATA_WIDTH, packed read data, same packing.
REQ-016 SHALL have port clear, input, 1, single-cycle request to start a clear sweep.
REQ-017 SHALL have port clear_busy, output, 1, high while a clear sweep is in progress.

Function
REQ-018 SHALL on rising clock with wN_en=1 update only lanes with wN_strb bit set at entry wN_addr; other lanes unchanged.
REQ-019 SHALL on both ports writing the same address merge lanes; where both strobes set a lane, port 1 data wins.
REQ-020 SHALL ignore writes with address >= DEPTH; reads of address >= DEPTH return 0.
REQ-021 SHALL with ZERO_REG=1 ignore writes to address 0 and return 0 for reads of address 0, including bypass.
REQ-022 SHALL with READ_REG=0 drive each r_data slot combinationally from its r_addr slot.
REQ-023 SHALL with READ_REG=1 register r_data on the rising clock; value reflects r_addr at that edge.
REQ-024 SHALL with BYPASS=1 return, for a read matching an active write address, stored data overlaid by enabled write lanes (port 1 priority), in either READ_REG mode.
REQ-025 SHALL with BYPASS=0 return pre-write stored data on same-cycle address match (READ_REG=0: new value visible after the edge).
REQ-026 SHALL implement clear FSM with states IDLE and SWEEP; IDLE->SWEEP on clear=1, sweep index set to 0.
REQ-027 SHALL in SWEEP zero one entry per cycle at sweep index, increment index, return to IDLE after writing entry DEPTH-1 (DEPTH cycles total).
REQ-028 SHALL drive clear_busy=1 exactly in SWEEP; clear asserted during SWEEP is ignored (no restart).
REQ-029 SHALL ignore w0/w1 writes while clear_busy=1 or on the cycle clear is accepted; reads stay live and return current partially cleared contents, no bypass.

Reset
REQ-030 SHALL on reset_n=0 asynchronously zero all entries, force FSM to IDLE, clear sweep index, clear_busy=0, registered r_data=0.
REQ-031 SHALL abort a sweep on reset mid-operation; after release entries are all zero and block is IDLE.
REQ-032 SHALL accept writes on the first rising edge after reset_n deasserts.

Verification
REQ-033 SHALL verify: DW=16, w0 addr 10 data 16'hABCD strb 2'b11; next cycle r_addr[0]=10 -> r_data[0]=16'hABCD; then w0 data 16'h1234 strb 2'b01 -> entry 10 = 16'hAB34.
REQ-034 SHALL verify: w0 and w1 both addr 5, w0 16'h1111 strb 2'b11, w1 16'h2222 strb 2'b10 -> entry 5 = 16'h2211.
REQ-035 SHALL verify BYPASS=1, READ_REG=0: w0 addr 3 data 16'h5A5A with r_addr[1]=3 same cycle -> r_data[1]=16'h5A5A before the edge; BYPASS=0 -> old value 16'h0000.
REQ-036 SHALL verify ZERO_REG=1: write 16'hFFFF to addr 0 -> read addr 0 = 16'h0000; write addr 1 -> reads 16'hFFFF.
REQ-037 SHALL verify clear with DEPTH=32: all entries written nonzero, pulse clear -> clear_busy high exactly 32 cycles, w0 write during sweep ignored, all entries read 0 afterwards.
REQ-038 SHALL verify reset_n pulsed low on sweep cycle 10 -> clear_busy=0 immediately, all entries 0, write after release succeeds.

Source files
------------

// File: rtl/multi_port_reg_file.sv
// Two-write, NUM_READ-read byte-strobed register file with a one-entry-per-cycle clear sweep.
// Reads are combinational or one cycle when READ_REG=1; there is no backpressure, and writes are dropped while a sweep runs.
module multi_port_reg_file #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 32,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 0,
    parameter int READ_REG   = 0
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             w0_en,
    input  logic [ADDR_WIDTH-1:0]            w0_addr,
    input  logic [DATA_WIDTH-1:0]            w0_data,
    input  logic [DATA_WIDTH/8-1:0]          w0_strb,
    input  logic                             w1_en,
    input  logic [ADDR_WIDTH-1:0]            w1_addr,
    input  logic [DATA_WIDTH-1:0]            w1_data,
    input  logic [DATA_WIDTH/8-1:0]          w1_strb,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]   r_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]   r_data,
    input  logic                             clear,
    output logic                             clear_busy
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
        $error("DATA_WIDTH must be a multiple of 8");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("DEPTH must lie in 1 .. 2**ADDR_WIDTH");
    end
    if (NUM_READ < 1) begin : g_bad_nr
        $error("NUM_READ must be at least 1");
    end

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   sweep_idx_q;
    logic                    clear_busy_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   mem_d [DEPTH];
    logic [NUM_READ*DATA_WIDTH-1:0] rd_d;
    logic                    wr_ok;
    logic                    w0_act;
    logic                    w1_act;

    // Port 1 is applied last so it wins any lane both ports enable.
    function automatic logic [DATA_WIDTH-1:0] merge(
        input logic [DATA_WIDTH-1:0] base,
        input logic                  h0,
        input logic [DATA_WIDTH-1:0] d0,
        input logic [NB-1:0]         s0,
        input logic                  h1,
        input logic [DATA_WIDTH-1:0] d1,
        input logic [NB-1:0]         s1
    );
        logic [DATA_WIDTH-1:0] res;
        res = base;
        for (int b = 0; b < NB; b++) begin
            if (h0 && s0[b]) res[8*b +: 8] = d0[8*b +: 8];
            if (h1 && s1[b]) res[8*b +: 8] = d1[8*b +: 8];
        end
        return res;
    endfunction

    // Out-of-range and (optionally) entry-0 writes are squashed here, so neither storage nor bypass sees them.
    assign wr_ok  = !clear_busy_q && !clear;
    assign w0_act = w0_en && wr_ok && ({1'b0, w0_addr} < DEPTH_L)
                    && !((ZERO_REG != 0) && (w0_addr == '0));
    assign w1_act = w1_en && wr_ok && ({1'b0, w1_addr} < DEPTH_L)
                    && !((ZERO_REG != 0) && (w1_addr == '0));

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = merge(mem_q[i],
                             w0_act && (w0_addr == ADDR_WIDTH'(i)), w0_data, w0_strb,
                             w1_act && (w1_addr == ADDR_WIDTH'(i)), w1_data, w1_strb);
            if (clear_busy_q && (sweep_idx_q == ADDR_WIDTH'(i))) mem_d[i] = '0;
        end
    end

    always_comb begin
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] base;
        rd_d = '0;
        ra   = '0;
        base = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            ra   = r_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            base = '0;
            for (int j = 0; j < DEPTH; j++) begin
                if (ra == ADDR_WIDTH'(j)) base = mem_q[j];
            end
            if ((ZERO_REG != 0) && (ra == '0)) base = '0;
            if (BYPASS != 0) begin
                base = merge(base, w0_act && (w0_addr == ra), w0_data, w0_strb,
                                   w1_act && (w1_addr == ra), w1_data, w1_strb);
            end
            rd_d[k*DATA_WIDTH +: DATA_WIDTH] = base;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sweep_idx_q  <= '0;
            clear_busy_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        state_q      <= SWEEP;
                        sweep_idx_q  <= '0;
                        clear_busy_q <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (sweep_idx_q == LAST_IDX) begin
                        state_q      <= IDLE;
                        sweep_idx_q  <= '0;
                        clear_busy_q <= 1'b0;
                    end else begin
                        sweep_idx_q  <= sweep_idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    sweep_idx_q  <= '0;
                    clear_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign clear_busy = clear_busy_q;

    if (READ_REG != 0) begin : g_rd_reg
        logic [NUM_READ*DATA_WIDTH-1:0] r_data_q;
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) r_data_q <= '0;
            else          r_data_q <= rd_d;
        end
        assign r_data = r_data_q;
    end else begin : g_rd_comb
        assign r_data = rd_d;
    end
endmodule
